// File: rtl/rv32i_decode_pkg.sv
// Shared encodings for the RV32I decoder: opcodes, immediate formats,
// PC-update modes, ALU functions and the bundled control word.
package rv32i_decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  localparam logic [2:0] PC_IMM_4    = 3'd0;
  localparam logic [2:0] PC_IMM_0    = 3'd1;
  localparam logic [2:0] PC_IMM_BZ   = 3'd2;
  localparam logic [2:0] PC_IMM_BNZ  = 3'd3;
  localparam logic [2:0] PC_IMM_JAL  = 3'd4;
  localparam logic [2:0] PC_IMM_JALR = 3'd5;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SLL  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SRL  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic       alu_imm;
    logic [2:0] alu_op;
    logic       alu_alt;
    logic       reg_wen;
    logic [2:0] pc_imm;
    logic       dmem_write;
    logic       dmem_read;
    logic       dmem_reg;
    logic       alu_a0;
    logic       alu_apc;
    logic       alu_b4;
  } ctrl_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Immediate generator: assembles the sign-extended immediate for the
// selected instruction format from the raw instruction bits.
module rv32i_imm_gen
  import rv32i_decode_pkg::*;
(
  input  imm_type_e   imm_type_i,
  input  logic [31:7] ins_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (imm_type_i)
      IMM_I:   imm_o = {{20{ins_i[31]}}, ins_i[31:20]};
      IMM_S:   imm_o = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
      IMM_B:   imm_o = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25],
                        ins_i[11:8], 1'b0};
      IMM_U:   imm_o = {ins_i[31:12], 12'b0};
      IMM_J:   imm_o = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20],
                        ins_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode.sv
// RV32I control decoder for the single-cycle core, with a sticky halt flop
// that freezes the core after the first illegal instruction.
module rv32i_decode
  import rv32i_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op_code,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:7] ins_i,
  output logic [31:0] imm,
  output logic        op_illegal,
  output logic        alu_imm,
  output logic [2:0]  alu_op,
  output logic        alu_alt,
  output logic        reg_wen,
  output logic [2:0]  pc_imm,
  output logic        dmem_write,
  output logic        dmem_read,
  output logic        dmem_reg,
  output logic        alu_a0,
  output logic        alu_apc,
  output logic        alu_b4,
  output logic        halted
);

  imm_type_e imm_type;
  ctrl_t     dec;
  ctrl_t     ctrl;
  logic      dec_illegal;
  logic      halted_q, halted_d;

  always_comb begin
    imm_type = IMM_NONE;
    case (op_code)
      OPC_LUI, OPC_AUIPC:             imm_type = IMM_U;
      OPC_JAL:                        imm_type = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: imm_type = IMM_I;
      OPC_BRANCH:                     imm_type = IMM_B;
      OPC_STORE:                      imm_type = IMM_S;
      default:                        imm_type = IMM_NONE;
    endcase
  end

  rv32i_imm_gen u_imm_gen (
    .imm_type_i (imm_type),
    .ins_i      (ins_i),
    .imm_o      (imm)
  );

  always_comb begin
    dec         = '0;
    dec.pc_imm  = PC_IMM_4;
    dec_illegal = 1'b0;
    case (op_code)
      OPC_LUI: begin
        dec.alu_a0  = 1'b1;
        dec.alu_imm = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_apc = 1'b1;
        dec.alu_imm = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_apc = 1'b1;
        dec.alu_b4  = 1'b1;
        dec.reg_wen = 1'b1;
        dec.pc_imm  = PC_IMM_JAL;
      end
      OPC_JALR: begin
        dec.alu_apc = 1'b1;
        dec.alu_b4  = 1'b1;
        dec.reg_wen = 1'b1;
        dec.pc_imm  = PC_IMM_JALR;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        // Equality uses SUB and tests for zero; magnitude compares use SLT(U).
        case (funct3)
          3'b000: begin dec.alu_alt = 1'b1;   dec.pc_imm = PC_IMM_BZ;  end
          3'b001: begin dec.alu_alt = 1'b1;   dec.pc_imm = PC_IMM_BNZ; end
          3'b100: begin dec.alu_op = ALU_SLT;  dec.pc_imm = PC_IMM_BNZ; end
          3'b101: begin dec.alu_op = ALU_SLT;  dec.pc_imm = PC_IMM_BZ;  end
          3'b110: begin dec.alu_op = ALU_SLTU; dec.pc_imm = PC_IMM_BNZ; end
          3'b111: begin dec.alu_op = ALU_SLTU; dec.pc_imm = PC_IMM_BZ;  end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.alu_imm   = 1'b1;
        dec.dmem_read = 1'b1;
        dec.dmem_reg  = 1'b1;
        dec.reg_wen   = 1'b1;
        dec_illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                        (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.alu_imm    = 1'b1;
        dec.dmem_write = 1'b1;
        dec_illegal    = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        dec.alu_imm = 1'b1;
        dec.alu_op  = funct3;
        dec.reg_wen = 1'b1;
        if (funct3 == ALU_SRL) begin
          dec.alu_alt = funct7[5];
          dec_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end else if (funct3 == ALU_SLL) begin
          dec_illegal = (funct7 != F7_BASE);
        end
      end
      OPC_OP: begin
        dec.alu_op  = funct3;
        dec.alu_alt = funct7[5];
        dec.reg_wen = 1'b1;
        dec_illegal = !((funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) &&
                         ((funct3 == ALU_ADD) || (funct3 == ALU_SRL))));
      end
      OPC_MISC_MEM: ;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Reset wins over everything; otherwise an illegal op or a halted core
  // both squash the control word and freeze the PC.
  always_comb begin
    ctrl       = dec;
    op_illegal = dec_illegal;
    if (reset) begin
      ctrl        = '0;
      ctrl.pc_imm = PC_IMM_4;
      op_illegal  = 1'b0;
    end else if (dec_illegal || halted_q) begin
      ctrl        = '0;
      ctrl.pc_imm = PC_IMM_0;
    end
  end

  always_comb begin
    halted_d = halted_q;
    if (reset)           halted_d = 1'b0;
    else if (op_illegal) halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    halted_q <= halted_d;
  end

  assign alu_imm    = ctrl.alu_imm;
  assign alu_op     = ctrl.alu_op;
  assign alu_alt    = ctrl.alu_alt;
  assign reg_wen    = ctrl.reg_wen;
  assign pc_imm     = ctrl.pc_imm;
  assign dmem_write = ctrl.dmem_write;
  assign dmem_read  = ctrl.dmem_read;
  assign dmem_reg   = ctrl.dmem_reg;
  assign alu_a0     = ctrl.alu_a0;
  assign alu_apc    = ctrl.alu_apc;
  assign alu_b4     = ctrl.alu_b4;
  assign halted     = halted_q;

endmodule

// File: tb/tb_rv32i_decode.sv
// Directed bench for rv32i_decode: a whole-word reference model checked on
// every negedge, plus literal expectations from the instruction encodings.
module tb_rv32i_decode;

  typedef struct packed {
    logic [31:0] imm;
    logic        ill;
    logic        aimm;
    logic [2:0]  aop;
    logic        alt;
    logic        wen;
    logic [2:0]  pc;
    logic        dw;
    logic        dr;
    logic        dreg;
    logic        a0;
    logic        apc;
    logic        b4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s = 1'b1;
  logic [31:0] cur = 32'h0000_0013;
  logic        check_en = 1'b0;
  logic        m_halted = 1'b0;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] imm;
  logic        op_illegal, alu_imm, alu_alt, reg_wen;
  logic [2:0]  alu_op, pc_imm;
  logic        dmem_write, dmem_read, dmem_reg, alu_a0, alu_apc, alu_b4, halted;
  exp_t        got, m_exp;

  always #5 clk = ~clk;

  rv32i_decode dut (
    .clk        (clk),
    .reset      (rst_s),
    .op_code    (cur[6:0]),
    .funct3     (cur[14:12]),
    .funct7     (cur[31:25]),
    .ins_i      (cur[31:7]),
    .imm        (imm),
    .op_illegal (op_illegal),
    .alu_imm    (alu_imm),
    .alu_op     (alu_op),
    .alu_alt    (alu_alt),
    .reg_wen    (reg_wen),
    .pc_imm     (pc_imm),
    .dmem_write (dmem_write),
    .dmem_read  (dmem_read),
    .dmem_reg   (dmem_reg),
    .alu_a0     (alu_a0),
    .alu_apc    (alu_apc),
    .alu_b4     (alu_b4),
    .halted     (halted)
  );

  assign got = {imm, op_illegal, alu_imm, alu_op, alu_alt, reg_wen, pc_imm,
                dmem_write, dmem_read, dmem_reg, alu_a0, alu_apc, alu_b4};

  // Reference: classify the full instruction word, build immediates with
  // signed arithmetic, then apply illegal / reset / halt squashing.
  function automatic exp_t model(input logic [31:0] w, input logic rst,
                                 input logic hlt);
    exp_t        e;
    int          sw;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [31:0] keep;
    sw = w;
    f3 = w[14:12];
    f7 = w[31:25];
    e = '0;
    legal = 1'b1;
    case (w[6:0])
      7'h37: begin e.imm = w & 32'hFFFF_F000; e.a0 = 1; e.aimm = 1; e.wen = 1; end
      7'h17: begin e.imm = w & 32'hFFFF_F000; e.apc = 1; e.aimm = 1; e.wen = 1; end
      7'h6F: begin
        e.imm = (32'(sw >>> 31) << 20) | (32'(w[19:12]) << 12) |
                (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        e.apc = 1; e.b4 = 1; e.wen = 1; e.pc = 3'd4;
      end
      7'h67: begin
        e.imm = 32'(sw >>> 20);
        e.apc = 1; e.b4 = 1; e.wen = 1; e.pc = 3'd5;
        legal = (f3 == 3'd0);
      end
      7'h63: begin
        e.imm = (32'(sw >>> 31) << 12) | (32'(w[7]) << 11) |
                (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        case (f3)
          3'd0: begin e.alt = 1; e.pc = 3'd2; end
          3'd1: begin e.alt = 1; e.pc = 3'd3; end
          3'd4: begin e.aop = 3'd2; e.pc = 3'd3; end
          3'd5: begin e.aop = 3'd2; e.pc = 3'd2; end
          3'd6: begin e.aop = 3'd3; e.pc = 3'd3; end
          3'd7: begin e.aop = 3'd3; e.pc = 3'd2; end
          default: legal = 1'b0;
        endcase
      end
      7'h03: begin
        e.imm = 32'(sw >>> 20);
        e.aimm = 1; e.dr = 1; e.dreg = 1; e.wen = 1;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                (f3 == 3'd4) || (f3 == 3'd5);
      end
      7'h23: begin
        e.imm = (32'(sw >>> 25) << 5) | 32'(w[11:7]);
        e.aimm = 1; e.dw = 1;
        legal = (f3 <= 3'd2);
      end
      7'h13: begin
        e.imm = 32'(sw >>> 20);
        e.aimm = 1; e.aop = f3; e.wen = 1;
        if (f3 == 3'd5) e.alt = f7[5];
        if (f3 == 3'd1) legal = (f7 == 7'd0);
        if (f3 == 3'd5) legal = (f7 == 7'd0) || (f7 == 7'd32);
      end
      7'h33: begin
        e.aop = f3; e.alt = f7[5]; e.wen = 1;
        legal = (f7 == 7'd0) || ((f7 == 7'd32) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      7'h0F: ;
      default: legal = 1'b0;
    endcase
    keep = e.imm;
    if (rst) begin
      e = '0;
      e.imm = keep;
    end else if (!legal || hlt) begin
      e = '0;
      e.imm = keep;
      e.pc = 3'd1;
      e.ill = !legal;
    end
    return e;
  endfunction

  always_comb m_exp = model(cur, rst_s, m_halted);

  always @(posedge clk) begin
    if (rst_s)          m_halted <= 1'b0;
    else if (m_exp.ill) m_halted <= 1'b1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (got !== m_exp || halted !== m_halted) begin
        errors++;
        $display("FAIL model_cmp t=%0t ins=%h rst=%b got=%h/h%b want=%h/h%b",
                 $time, cur, rst_s, got, halted, m_exp, m_halted);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ins=%h got=%h want=%h", name, cur, act, exp);
    end
  endtask

  // Apply a word one tick after the edge and settle before literal checks.
  task automatic drive(input logic [31:0] w, input logic r);
    @(posedge clk);
    #1;
    cur = w;
    rst_s = r;
    #2;
  endtask

  localparam logic [31:0] ADDI  = 32'hFFF0_0093;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic [31:0] extra [24] = '{
    32'h1234_50B7, 32'hFFFF_F097, 32'h4020_D093, 32'h0020_D093, 32'h0220_9093,
    32'h0010_9093, 32'hFE20_9EE3, 32'h0020_E463, 32'h0020_F463, 32'h0000_8083,
    32'h0000_D083, 32'h0000_B083, 32'hFE11_0FA3, 32'h0011_3023, 32'h0000_A063,
    32'h0000_90E7, 32'h0000_000F, 32'h0020_E033, 32'h0020_F033, 32'h4020_D033,
    32'h4020_C033, 32'h0000_007F, 32'hFFDF_F0EF, 32'h0200_8033
  };

  initial begin
    drive(ADDI, 1'b1);
    chk("rst_reg_wen", 32'(reg_wen), 0);
    chk("rst_pc_imm", 32'(pc_imm), 0);
    chk("rst_alu_imm", 32'(alu_imm), 0);
    chk("rst_imm_ungated", imm, 32'hFFFF_FFFF);

    drive(ADDI, 1'b0);
    check_en = 1'b1;
    chk("reset_halted", 32'(halted), 0);
    chk("addi_imm", imm, 32'hFFFF_FFFF);
    chk("addi_alu_imm", 32'(alu_imm), 1);
    chk("addi_alu_op", 32'(alu_op), 0);
    chk("addi_reg_wen", 32'(reg_wen), 1);
    chk("addi_pc_imm", 32'(pc_imm), 0);

    drive(32'h0020_C463, 1'b0);
    chk("blt_imm", imm, 8);
    chk("blt_alu_op", 32'(alu_op), 2);
    chk("blt_alu_imm", 32'(alu_imm), 0);
    chk("blt_reg_wen", 32'(reg_wen), 0);
    chk("blt_pc_imm", 32'(pc_imm), 3);
    drive(32'h0020_D463, 1'b0);
    chk("bge_pc_imm", 32'(pc_imm), 2);

    drive(32'h0080_00EF, 1'b0);
    chk("jal_imm", imm, 8);
    chk("jal_apc_b4_wen", {29'd0, alu_apc, alu_b4, reg_wen}, 32'd7);
    chk("jal_pc_imm", 32'(pc_imm), 4);
    drive(32'h0000_80E7, 1'b0);
    chk("jalr_pc_imm", 32'(pc_imm), 5);

    drive(32'h0011_2223, 1'b0);
    chk("sw_imm", imm, 4);
    chk("sw_dmem_write", 32'(dmem_write), 1);
    chk("sw_reg_wen", 32'(reg_wen), 0);
    drive(32'h0041_2083, 1'b0);
    chk("lw_rd_reg_wen", {29'd0, dmem_read, dmem_reg, reg_wen}, 32'd7);

    drive(32'h4020_8033, 1'b0);
    chk("sub_alu_alt", 32'(alu_alt), 1);
    drive(32'h4020_9033, 1'b0);
    chk("sll_f7_illegal", 32'(op_illegal), 1);
    chk("sll_f7_pc_imm", 32'(pc_imm), 1);
    chk("sll_f7_reg_wen", 32'(reg_wen), 0);
    drive(ADDI, 1'b0);
    chk("halt_after_illegal", 32'(halted), 1);
    chk("halt_pc_imm", 32'(pc_imm), 1);
    chk("halt_op_illegal", 32'(op_illegal), 0);
    drive(ADDI, 1'b1);
    chk("halt_rst_cycle_pc", 32'(pc_imm), 0);
    drive(ADDI, 1'b0);
    chk("halt_cleared", 32'(halted), 0);
    chk("resume_reg_wen", 32'(reg_wen), 1);

    drive(ECALL, 1'b0);
    chk("ecall_illegal", 32'(op_illegal), 1);
    chk("ecall_pc_imm", 32'(pc_imm), 1);
    drive(ADDI, 1'b0);
    chk("ecall_halted", 32'(halted), 1);
    chk("ecall_halt_wen", 32'(reg_wen), 0);
    drive(ADDI, 1'b0);
    chk("ecall_halt_sticky", 32'(halted), 1);
    drive(ADDI, 1'b1);
    chk("ecall_rst_wen", 32'(reg_wen), 0);
    chk("ecall_rst_ill", 32'(op_illegal), 0);
    drive(ADDI, 1'b0);
    chk("ecall_rst_halted", 32'(halted), 0);

    foreach (extra[i]) begin
      drive(extra[i], 1'b0);
      if (extra[i] == 32'h1234_50B7) chk("lui_imm", imm, 32'h1234_5000);
      if (extra[i] == 32'hFE20_9EE3) chk("bne_neg_imm", imm, 32'hFFFF_FFFC);
      if (extra[i] == 32'hFFDF_F0EF) chk("jal_neg_imm", imm, 32'hFFFF_FFFC);
      if (extra[i] == 32'hFE11_0FA3) chk("sb_neg_imm", imm, 32'hFFFF_FFFF);
      if (extra[i] == 32'h4020_D093) chk("srai_alt", 32'(alu_alt), 1);
      drive(32'h0000_0013, 1'b1);
    end

    drive(32'h0000_0013, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
